// File: rtl/prod_bcd_converter_if.sv
// Handshake/result bundle between the multiplier and the BCD converter.
// The master drives start/prod; the slave returns status and the BCD result.
interface prod_bcd_converter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      prod;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start, prod,
        input  busy, done, sign, bcd
    );

    modport slave (
        input  start, prod,
        output busy, done, sign, bcd
    );
endinterface

// File: rtl/prod_bcd_converter.sv
// Sequential signed-binary to BCD converter (double dabble, one bit/clock).
// Result and sign are registered and only change on the done edge.
module prod_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    prod_bcd_converter_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sign;
    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]    r_scratch;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_sign_o;
    logic [BW-1:0]    r_bcd;
    logic [BW-1:0]    w_adj;
    logic [WIDTH-1:0] w_mag;

    // Absolute value; the most negative input maps to 2**(WIDTH-1) unsigned
    always_comb begin
        w_mag = bus.prod;
        if (bus.prod[WIDTH-1])
            w_mag = ~bus.prod + WIDTH'(1);
    end

    // Add-3 correction for every scratch digit >= 5 before the shift
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(WIDTH - 1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: capture, shift, and publish the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sign_o  <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign    <= bus.prod[WIDTH-1];
                        r_mag     <= w_mag;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= {w_adj[BW-2:0], r_mag[WIDTH-1]};
                    r_mag     <= r_mag << 1;
                    r_cnt     <= r_cnt + CW'(1);
                end
                S_DONE: begin
                    r_bcd    <= r_scratch;
                    r_sign_o <= r_sign;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sign = r_sign_o;
    assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_prod_bcd_converter.sv
// Self-checking bench for prod_bcd_converter.
// Expected results come from a decimal-arithmetic reference model.
module tb_prod_bcd_converter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    prod_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

    prod_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: {sign, hundreds, tens, units} from plain integer math
    function automatic logic [12:0] ref_conv(input logic [7:0] p);
        int v;
        int m;
        logic s;
        v = int'($signed(p));
        s = (v < 0);
        m = s ? -v : v;
        return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full conversion, starting and ending at a negedge with DUT idle
    task automatic do_conv(input logic [7:0] p, input string tag);
        logic [12:0] exp;
        int  lat;
        bit  seen;
        bit  busy_ok;
        exp = ref_conv(p);
        bus.start = 1'b1;
        bus.prod  = p;
        @(negedge clk);
        bus.start = 1'b0;
        bus.prod  = 8'($urandom);
        lat = 0;
        seen = 0;
        busy_ok = 1;
        while (!seen && lat <= 20) begin
            if (bus.done) begin
                seen = 1;
            end else begin
                if (!bus.busy) busy_ok = 0;
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'd9);
        chk({tag, "_busy_hi"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        chk({tag, "_res"}, 32'({bus.sign, bus.bcd}), 32'(exp));
        @(negedge clk);
        chk({tag, "_done1"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, 32'({bus.sign, bus.bcd}), 32'(exp));
    endtask

    initial begin
        int dk [$];
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.prod  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res", 32'({bus.sign, bus.bcd}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_conv(8'h40, "d40");
        chk("d40_bcd", 32'(bus.bcd), 32'h064);
        do_conv(8'hC8, "dC8");
        chk("dC8_res", 32'({bus.sign, bus.bcd}), 32'h1056);
        do_conv(8'h00, "d00");
        do_conv(8'h80, "d80");
        chk("d80_res", 32'({bus.sign, bus.bcd}), 32'h1128);
        do_conv(8'h7F, "d7F");
        chk("d7F_res", 32'({bus.sign, bus.bcd}), 32'h0127);

        for (int a = -8; a <= 7; a++)
            for (int b = -8; b <= 7; b++)
                do_conv(8'(a * b), "sweep");

        repeat (40) do_conv(8'($urandom), "rand");

        // Start pulses during SHIFT and DONE must be ignored
        bus.start = 1'b1;
        bus.prod  = 8'h40;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            bus.start = (k == 2 || k == 8);
            bus.prod  = 8'hC8;
            if (k == 9) begin
                chk("ign_done", 32'(bus.done), 32'd1);
                chk("ign_res", 32'({bus.sign, bus.bcd}), 32'h0064);
            end
            if (k >= 10) begin
                chk("ign_idle", 32'({bus.busy, bus.done}), 32'd0);
                chk("ign_keep", 32'({bus.sign, bus.bcd}), 32'h0064);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;

        // Start held high: a new result every 10 clocks
        bus.start = 1'b1;
        bus.prod  = 8'hC8;
        @(negedge clk);
        for (int k = 0; k <= 30; k++) begin
            if (bus.done) begin
                dk.push_back(k);
                chk("hold_res", 32'({bus.sign, bus.bcd}), 32'h1056);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("hold_cnt", 32'(dk.size()), 32'd3);
        for (int i = 1; i < dk.size(); i++)
            chk("hold_gap", 32'(dk[i] - dk[i-1]), 32'd10);
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
        chk("hold_drain", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a conversion
        bus.start = 1'b1;
        bus.prod  = 8'hC8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_res", 32'({bus.sign, bus.bcd}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_idle", 32'(bus.busy), 32'd0);
        do_conv(8'hF9, "dF9");
        chk("dF9_res", 32'({bus.sign, bus.bcd}), 32'h1007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
